// File: rtl/evt_pkg.sv
// Shared types and constants for the event record serializer.
// Defining EVT_SERIALIZER_CRC_EN adds the CRC state to the FSM encoding.
package evt_pkg;

    localparam int EVT_W      = 72;
    localparam int EVT_BEAT_W = 8;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef EVT_SERIALIZER_CRC_EN
        S_SEND,
        S_CRC
`else
        S_SEND
`endif
    } ser_state_e;

endpackage

// File: rtl/evt_crc8.sv
// CRC-8 accumulator: combinational byte update, registered state.
// Cleared at record load, advanced once per accepted data beat.
module evt_crc8
    import evt_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    function automatic logic [7:0] crc8_byte(
        input logic [7:0] c,
        input logic [7:0] b
    );
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ CRC8_POLY) : (x << 1);
        end
        return x;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc8_byte(crc_q, byte_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/evt_serializer.sv
// Pops W-bit records from a FIFO and streams them LSB beat first.
// EVT_SERIALIZER_CRC_EN appends a CRC-8 beat to every record.
module evt_serializer
    import evt_pkg::*;
#(
    parameter int W      = EVT_W,
    parameter int BEAT_W = EVT_BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [W-1:0]      fifo_pop_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       rec_count
);

    localparam int NBEATS = (W + BEAT_W - 1) / BEAT_W;
    localparam int SR_W   = NBEATS * BEAT_W;
    localparam int IDX_W  = $clog2(NBEATS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    ser_state_e        state_q;
    logic [SR_W-1:0]   shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_nx;
    logic              m_valid_q;
    logic              m_last_q;
    logic [15:0]       rec_q;
    logic              hs;
    logic              final_hs;
    logic              pop;

    assign hs       = m_valid_q && m_ready;
    assign final_hs = hs && m_last_q;
    assign pop      = !rst && !fifo_empty &&
                      (state_q == S_IDLE || final_hs);
    assign idx_nx   = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            rec_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q   <= SR_W'(fifo_pop_data);
                    idx_q     <= '0;
                    m_valid_q <= 1'b1;
`ifdef EVT_SERIALIZER_CRC_EN
                    m_last_q  <= 1'b0;
`else
                    m_last_q  <= (LAST_IDX == '0);
`endif
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        shift_q <= shift_q >> BEAT_W;
                        idx_q   <= idx_nx;
`ifdef EVT_SERIALIZER_CRC_EN
                        if (idx_q == LAST_IDX) begin
                            m_last_q <= 1'b1;
                            state_q  <= S_CRC;
                        end
`else
                        m_last_q <= (idx_nx == LAST_IDX);
                        if (m_last_q) begin
                            rec_q     <= rec_q + 16'd1;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            state_q   <= pop ? S_LOAD : S_IDLE;
                        end
`endif
                    end
                end
`ifdef EVT_SERIALIZER_CRC_EN
                S_CRC: begin
                    if (hs) begin
                        rec_q     <= rec_q + 16'd1;
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        state_q   <= pop ? S_LOAD : S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef EVT_SERIALIZER_CRC_EN
    logic [7:0] crc;

    evt_crc8 u_crc (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (state_q == S_LOAD),
        .en_i   (hs && state_q == S_SEND),
        .byte_i (shift_q[7:0]),
        .crc_o  (crc)
    );

    assign m_data = (state_q == S_CRC) ? BEAT_W'(crc)
                                       : shift_q[BEAT_W-1:0];
`else
    assign m_data = shift_q[BEAT_W-1:0];
`endif

    assign fifo_pop  = pop;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q != S_IDLE);
    assign rec_count = rec_q;

endmodule

// File: tb/tb_evt_serializer.sv
// Directed bench for evt_serializer with a small FIFO model.
// Beat counts follow EVT_SERIALIZER_CRC_EN when it is defined.
module tb_evt_serializer;

`ifdef EVT_SERIALIZER_CRC_EN
    localparam int NBT = 10;
`else
    localparam int NBT = 9;
`endif
    localparam int PERIOD = NBT + 1;

    localparam logic [71:0] R1 = 72'h12_3456_789A_BCDE_F011;
    localparam logic [71:0] R2 = 72'h01_0203_0405_0607_0809;
    localparam logic [71:0] R3 = 72'hFF_EEDD_CCBB_AA99_8877;
    localparam logic [71:0] R4 = 72'h00_0000_0000_0000_00C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [71:0] fifo_pop_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] rec_count;

    int total = 0;
    int bad = 0;

    evt_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .fifo_pop_data (fifo_pop_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .rec_count     (rec_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pop data appears the cycle after fifo_pop
    logic [71:0] recs [32];
    int n_avail = 0;
    int rd_ptr = 0;
    always @(posedge clk) begin
        if (fifo_pop) begin
            fifo_pop_data <= recs[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            fifo_empty <= (rd_ptr + 1 >= n_avail);
        end else begin
            fifo_empty <= (rd_ptr >= n_avail);
        end
    end

    int rdy_mode = 1;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            default: m_ready = ~m_ready;
        endcase
    end

    logic [7:0] bd [256];
    logic       bl [256];
    int         bc [256];
    int bcnt = 0;
    int pop_cnt = 0;
    int pop_cyc = 0;
    always @(negedge clk) begin
        if (fifo_pop) begin
            pop_cnt <= pop_cnt + 1;
            pop_cyc <= cyc;
        end
        if (m_valid && m_ready && bcnt < 256) begin
            bd[bcnt] <= m_data;
            bl[bcnt] <= m_last;
            bc[bcnt] <= cyc;
            bcnt <= bcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [71:0] r);
        recs[n_avail] = r;
        n_avail++;
    endtask

    // Waits for n logged beats, checking stall stability on the way
    task automatic wait_beats(input int n, input int budget);
        int k;
        logic pend;
        logic [7:0] sd;
        logic sl;
        k = 0;
        pend = 1'b0;
        sd = '0;
        sl = 1'b0;
        while (bcnt < n && k < budget) begin
            nclk();
            if (pend) begin
                check("stall_valid", 72'(m_valid), 72'(1));
                check("stall_data", 72'(m_data), 72'(sd));
                check("stall_last", 72'(m_last), 72'(sl));
            end
            pend = m_valid && !m_ready;
            sd = m_data;
            sl = m_last;
            k++;
        end
        check("beats_seen", 72'(bcnt >= n), 72'(1));
    endtask

    task automatic check_rec(input string tag, input int s,
                             input logic [71:0] r);
        logic [71:0] v;
        v = r;
        for (int i = 0; i < 9; i++) begin
            check({tag, "_data"}, 72'(bd[s+i]), 72'(v[7:0]));
            v = v >> 8;
        end
        for (int i = 0; i < NBT; i++) begin
            check({tag, "_last"}, 72'(bl[s+i]), 72'(i == NBT - 1));
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [71:0] r);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 72; i++) begin
            logic fb;
            fb = c[7] ^ r[(i / 8) * 8 + 7 - (i % 8)];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    initial begin
        int s;
        int p0;
        @(posedge clk);
        #1;
        push(R1);
        repeat (3) nclk();
        check("rst_pop", 72'(fifo_pop), 72'(0));
        check("rst_valid", 72'(m_valid), 72'(0));
        check("rst_last", 72'(m_last), 72'(0));
        check("rst_data", 72'(m_data), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_count", 72'(rec_count), 72'(0));

        // single record, ready held high
        @(posedge clk);
        #1;
        rst = 1'b0;
        s = bcnt;
        p0 = pop_cnt;
        wait_beats(s + NBT, 40);
        repeat (2) nclk();
        check_rec("r1", s, R1);
        check("r1_latency", 72'(bc[s] - pop_cyc), 72'(2));
        check("r1_pops", 72'(pop_cnt - p0), 72'(1));
        check("r1_nbeats", 72'(bcnt - s), 72'(NBT));
        check("r1_count", 72'(rec_count), 72'(1));

        // same record under a 1010 ready pattern
        rdy_mode = 2;
        s = bcnt;
        push(R1);
        wait_beats(s + NBT, 80);
        repeat (3) nclk();
        check_rec("r1_stall", s, R1);
        check("stall_nbeats", 72'(bcnt - s), 72'(NBT));
        check("stall_count", 72'(rec_count), 72'(2));

        // three queued records back to back
        rdy_mode = 1;
        repeat (2) nclk();
        s = bcnt;
        p0 = pop_cnt;
        push(R2);
        push(R3);
        push(R4);
        wait_beats(s + 3 * NBT, 120);
        repeat (5) nclk();
        check("b2b_pops", 72'(pop_cnt - p0), 72'(3));
        check("b2b_nbeats", 72'(bcnt - s), 72'(3 * NBT));
        check("b2b_per1", 72'(bc[s+NBT] - bc[s]), 72'(PERIOD));
        check("b2b_per2", 72'(bc[s+2*NBT] - bc[s+NBT]), 72'(PERIOD));
        check("b2b_gap", 72'(bc[s+NBT] - bc[s+NBT-1]), 72'(2));
        check_rec("r2", s, R2);
        check_rec("r3", s + NBT, R3);
        check_rec("r4", s + 2 * NBT, R4);
        check("b2b_count", 72'(rec_count), 72'(5));

        // idle with an empty FIFO
        for (int i = 0; i < 20; i++) begin
            nclk();
            check("idle", 72'({fifo_pop, m_valid, busy}), 72'(0));
        end

        // reset after the fourth beat of a record
        s = bcnt;
        push(R1);
        wait_beats(s + 4, 40);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy_mode = 0;
        nclk();
        nclk();
        check("mid_valid", 72'(m_valid), 72'(0));
        check("mid_busy", 72'(busy), 72'(0));
        check("mid_count", 72'(rec_count), 72'(0));
        check("mid_data", 72'(m_data), 72'(0));
        check("mid_nbeats", 72'(bcnt - s), 72'(4));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        s = bcnt;
        push(R2);
        wait_beats(s + NBT, 40);
        repeat (2) nclk();
        check_rec("after_rst", s, R2);
        check("after_rst_count", 72'(rec_count), 72'(1));

`ifdef EVT_SERIALIZER_CRC_EN
        s = bcnt;
        push(72'h0);
        push(72'h1);
        wait_beats(s + 2 * NBT, 80);
        repeat (2) nclk();
        check_rec("crc_zero", s, 72'h0);
        check("crc_zero_beat", 72'(bd[s+9]), 72'(8'h00));
        check_rec("crc_one", s + NBT, 72'h1);
        check("crc_one_beat", 72'(bd[s+NBT+9]), 72'(crc_ref(72'h1)));
        check("crc_count", 72'(rec_count), 72'(3));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
